// File: rtl/shake_arbiter_pkg.sv
// Shared definitions for the two-requester SHAKE core arbiter.
// Holds the state encoding, the default parameter values and a counter-width helper.
package shake_arbiter_pkg;

    localparam int W_DEFAULT         = 32;
    localparam int FLUSH_CYC_DEFAULT = 2;
    localparam int TIMEOUT_DEFAULT   = 4095;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN0  = 2'd1;
    localparam logic [1:0] ST_OWN1  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } requester_e;

    // Bits needed to hold the values 0..maxval.
    function automatic int cnt_width(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/shake_arbiter_watchdog.sv
// Session watchdog: counts cycles without a handshake and strobes on reaching TIMEOUT.
// The counter saturates at TIMEOUT and never wraps.
module shake_watchdog
    import shake_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = inc_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/shake_arbiter.sv
// Round-robin arbiter giving one of two requesters exclusive use of a SHAKE core.
// Data paths are pure muxes; only the session control state is registered.
module shake_arbiter
    import shake_arbiter_pkg::*;
#(
    parameter int W         = W_DEFAULT,
    parameter int FLUSH_CYC = FLUSH_CYC_DEFAULT,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_i,
    input  logic         req1_i,
    input  logic         rel0_i,
    input  logic         rel1_i,
    output logic         gnt0_o,
    output logic         gnt1_o,

    input  logic         din_valid0_i,
    input  logic [W-1:0] din0_i,
    input  logic         dout_ready0_i,
    output logic         din_ready0_o,
    output logic         dout_valid0_o,
    output logic [W-1:0] dout0_o,

    input  logic         din_valid1_i,
    input  logic [W-1:0] din1_i,
    input  logic         dout_ready1_i,
    output logic         din_ready1_o,
    output logic         dout_valid1_o,
    output logic [W-1:0] dout1_o,

    output logic         din_valid_shake_o,
    output logic [W-1:0] din_shake_o,
    output logic         dout_ready_shake_o,
    input  logic         din_ready_shake_i,
    input  logic         dout_valid_shake_i,
    input  logic [W-1:0] dout_shake_i,

    output logic         force_done_shake_o,
    output logic         timeout_err_o
);

    localparam int FW = cnt_width(FLUSH_CYC);
    // FLUSH_CYC is expected to be at least 1; the counter runs FLUSH_CYC-1 down to 0.
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC - 1);

    logic [1:0]    rst_sync_q;
    logic          rst_n;
    logic [1:0]    state_q, state_d;
    logic [FW-1:0] flush_q, flush_d;
    requester_e    last_q, last_d;
    logic          err_q, err_d;

    logic own0, own1, owning;
    logic grant, handshake, expire, end_session;

    // Reset asserts asynchronously but is released only on a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    assign own0   = (state_q == ST_OWN0);
    assign own1   = (state_q == ST_OWN1);
    assign owning = own0 || own1;

    assign din_valid_shake_o  = own0 ? din_valid0_i  : (own1 ? din_valid1_i  : 1'b0);
    assign din_shake_o        = own0 ? din0_i        : (own1 ? din1_i        : '0);
    assign dout_ready_shake_o = own0 ? dout_ready0_i : (own1 ? dout_ready1_i : 1'b0);

    assign din_ready0_o  = own0 && din_ready_shake_i;
    assign dout_valid0_o = own0 && dout_valid_shake_i;
    assign dout0_o       = own0 ? dout_shake_i : '0;
    assign din_ready1_o  = own1 && din_ready_shake_i;
    assign dout_valid1_o = own1 && dout_valid_shake_i;
    assign dout1_o       = own1 ? dout_shake_i : '0;

    assign handshake = (din_valid_shake_o && din_ready_shake_i) ||
                       (dout_valid_shake_i && dout_ready_shake_o);

    shake_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst_n),
        .clear_i  (grant || handshake || !owning),
        .inc_i    (owning),
        .expire_o (expire)
    );

    // A watchdog expiry ends the session exactly like a release from the owner.
    assign end_session        = (own0 && rel0_i) || (own1 && rel1_i) || expire;
    assign force_done_shake_o = end_session;
    assign gnt0_o             = own0;
    assign gnt1_o             = own1;
    assign timeout_err_o      = err_q;

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        last_d  = last_q;
        grant   = 1'b0;
        err_d   = err_q || expire;
        case (state_q)
            ST_IDLE: begin
                if (req0_i && (!req1_i || (last_q == REQ1))) begin
                    state_d = ST_OWN0;
                    last_d  = REQ0;
                    grant   = 1'b1;
                end else if (req1_i) begin
                    state_d = ST_OWN1;
                    last_d  = REQ1;
                    grant   = 1'b1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (end_session) begin
                    state_d = ST_FLUSH;
                    flush_d = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (flush_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_d = flush_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            flush_q <= '0;
            last_q  <= REQ1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/shake_arbiter.md
SHAKE_ARBITER -- requirements
Module: shake_arbiter

Interface
REQ-001 SHALL have parameter W, default 32: width of the SHAKE data words.
REQ-002 SHALL have parameter FLUSH_CYC, default 2: number of idle cycles after force_done before the next grant.
REQ-003 SHALL have parameter TIMEOUT, default 4095: maximum number of cycles a grant may go without a data handshake.
REQ-004 clk  input  1  clock; every state element SHALL update on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req0, req1  input  1 each  requester i asks for exclusive use of the SHAKE core.
REQ-007 rel0, rel1  input  1 each  single-cycle pulse: requester i ends its session.
REQ-008 gnt0, gnt1  output  1 each  requester i owns the core.
REQ-009 din_valid_i, din_i[W-1:0], dout_ready_i  input  per requester  upstream side of the stream.
REQ-010 din_ready_i, dout_valid_i, dout_i[W-1:0]  output  per requester  returned stream signals.
REQ-011 din_valid_shake, din_shake[W-1:0], dout_ready_shake  output  signals to the core.
REQ-012 din_ready_shake, dout_valid_shake, dout_shake[W-1:0]  input  signals from the core.
REQ-013 force_done_shake  output  1  core abort/finish strobe.
REQ-014 timeout_err  output  1  sticky flag: a session was aborted by the watchdog.

Function
REQ-015 SHALL implement the states IDLE, OWN0, OWN1 and FLUSH.
REQ-016 IDLE: if only reqi is high, the next state SHALL be OWNi with gnti high from the following cycle (one-cycle grant latency).
REQ-017 IDLE with req0 and req1 both high: SHALL grant the requester that was not granted last (round robin); after reset, requester 0 SHALL win.
REQ-018 OWNi: din_valid_shake, din_shake and dout_ready_shake SHALL combinationally equal requester i's inputs.
REQ-019 OWNi: din_ready_i, dout_valid_i and dout_i SHALL combinationally equal the core outputs.
REQ-020 The non-owning requester SHALL see din_ready=0 and dout_valid=0; its dout SHALL be 0.
REQ-021 In IDLE and FLUSH, every core input SHALL be 0.
REQ-022 In OWNi, reli SHALL assert force_done_shake for exactly one cycle and move the state to FLUSH on the same edge.
REQ-023 rel from a requester that is not the owner, and any rel pulse in IDLE or FLUSH, SHALL be ignored.
REQ-024 The grant SHALL be held until release; a drop of req while granted SHALL NOT revoke it.
REQ-025 FLUSH SHALL last exactly FLUSH_CYC cycles, counted by a down-counter, and then return to IDLE.
REQ-026 A new grant SHALL first be possible at FLUSH_CYC+1 cycles after the force_done cycle.
REQ-027 Watchdog counter: cleared on grant and on every din or dout handshake (valid and ready both high); incremented otherwise while in OWNi.
REQ-028 When the watchdog counter reaches TIMEOUT, the arbiter SHALL behave as if reli had been received and SHALL set timeout_err.
REQ-029 timeout_err SHALL be cleared only by reset.
REQ-030 The watchdog counter SHALL saturate and never wrap; its width SHALL be clog2(TIMEOUT+1).
REQ-031 The last-granted pointer SHALL update on every grant.

Reset
REQ-032 While rst is low: state IDLE, gnt0/gnt1=0, force_done_shake=0, timeout_err=0, both counters 0, last-granted=1, all core inputs 0.
REQ-033 Reset asserted mid-session SHALL drop the grant immediately, without a force_done pulse.
REQ-034 Release from reset SHALL be taken synchronously to clk.

Structure
REQ-035 State encoding and the default values of W, FLUSH_CYC and TIMEOUT SHALL live in the shared package.
REQ-036 The watchdog SHALL be one sub-module, shake_watchdog (load/clear, increment, saturate, expire strobe).
REQ-037 No buffering SHALL exist on the data paths; the only registered elements SHALL be control state.

Verification
REQ-038 req0=1 in IDLE: gnt0=1 one cycle later; a 32-bit word handshake reaches din_shake unchanged.
REQ-039 req0 and req1 high together after reset: gnt0 first; after rel0 and 2 FLUSH cycles, gnt1; with both high again, gnt0.
REQ-040 rel1 pulsed while OWN0: ignored; gnt0 stays high; force_done_shake stays 0.
REQ-041 OWN1 with no handshakes, TIMEOUT=15: force_done_shake pulses on the 16th cycle after grant; timeout_err=1; FLUSH follows.
REQ-042 rst low while OWN0 in mid-stream: gnt0=0 and core inputs 0 asynchronously; the next grant goes to requester 0.
REQ-043 Core dout_valid=1 during FLUSH: dout_valid0/1 stay 0; no handshake is counted.
